// File: rtl/meas_sequencer_if.sv
// Handshake bundle between the measurement sequencer, the measurement core,
// the UART sender and the button/auto-run inputs.
interface meas_sequencer_if;
  logic        trig_n;
  logic        auto_en;
  logic        alt_en;
  logic        meas_done;
  logic        tx_busy;
  logic        meas_start;
  logic        tx_start;
  logic        ch_sel;
  logic        tx_ch;
  logic        busy;
  logic        timeout_err;
  logic [15:0] seq_cnt;

  modport master (
    input  trig_n, auto_en, alt_en, meas_done, tx_busy,
    output meas_start, tx_start, ch_sel, tx_ch, busy, timeout_err, seq_cnt
  );

  modport slave (
    output trig_n, auto_en, alt_en, meas_done, tx_busy,
    input  meas_start, tx_start, ch_sel, tx_ch, busy, timeout_err, seq_cnt
  );
endinterface

// File: rtl/meas_sequencer.sv
// Measurement sequencer: start core, wait for result, send it over UART,
// then hold a guard interval and optionally swap the input channel.
module meas_sequencer #(
  parameter int unsigned PERIOD_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TMR_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  meas_sequencer_if.master sif
);
  localparam int unsigned CNT_W = 16;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(PERIOD_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_MEAS, S_SEND, S_WAIT_TX, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       trig_sync_q;
  logic             trig_edge;
  logic             auto_q, done_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             seen_busy_q, seen_busy_d;
  logic             ch_sel_q, ch_sel_d;
  logic             tx_ch_q, tx_ch_d;
  logic             err_q, err_d;
  logic             meas_start_q, meas_start_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;

  // [1] is the synchronized button level, [2] its value one cycle earlier
  assign trig_edge = trig_sync_q[2] & ~trig_sync_q[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      trig_sync_q  <= 3'b111;
      auto_q       <= 1'b0;
      done_q       <= 1'b0;
      timer_q      <= '0;
      seen_busy_q  <= 1'b0;
      ch_sel_q     <= 1'b0;
      tx_ch_q      <= 1'b0;
      err_q        <= 1'b0;
      meas_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      seq_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      trig_sync_q  <= {trig_sync_q[1:0], sif.trig_n};
      auto_q       <= sif.auto_en;
      done_q       <= sif.meas_done;
      timer_q      <= timer_d;
      seen_busy_q  <= seen_busy_d;
      ch_sel_q     <= ch_sel_d;
      tx_ch_q      <= tx_ch_d;
      err_q        <= err_d;
      meas_start_q <= meas_start_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= (state_d != S_IDLE);
      seq_cnt_q    <= seq_cnt_d;
    end
  end

  // Next state; pulses are computed here so they register together with the state
  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    seen_busy_d  = seen_busy_q;
    ch_sel_d     = ch_sel_q;
    tx_ch_d      = tx_ch_q;
    err_d        = err_q;
    seq_cnt_d    = seq_cnt_q;
    meas_start_d = 1'b0;
    tx_start_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig_edge || auto_q) begin
          state_d      = S_START;
          meas_start_d = 1'b1;
          tx_ch_d      = ch_sel_q;
          timer_d      = '0;
          if (trig_edge) err_d = 1'b0;
        end
      end
      S_START: state_d = S_WAIT_MEAS;
      S_WAIT_MEAS: begin
        if (done_q) begin
          state_d = S_SEND;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
          timer_d = '0;
        end
      end
      S_SEND: begin
        if (!sif.tx_busy) begin
          tx_start_d  = 1'b1;
          timer_d     = '0;
          seen_busy_d = 1'b0;
          state_d     = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (sif.tx_busy) seen_busy_d = 1'b1;
        if (seen_busy_q && !sif.tx_busy) begin
          seq_cnt_d = seq_cnt_q + 1'b1;
          state_d   = S_HOLD;
          timer_d   = '0;
        end else if (!seen_busy_q && timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
          timer_d = '0;
        end
      end
      S_HOLD: begin
        // Channel swaps only here so the input mux settles before the next start
        if (timer_q == PER_LAST) begin
          if (sif.alt_en) ch_sel_d = ~ch_sel_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sif.meas_start  = meas_start_q;
  assign sif.tx_start    = tx_start_q;
  assign sif.ch_sel      = ch_sel_q;
  assign sif.tx_ch       = tx_ch_q;
  assign sif.busy        = busy_q;
  assign sif.timeout_err = err_q;
  assign sif.seq_cnt     = seq_cnt_q;
endmodule

// File: tb/tb_meas_sequencer.sv
// Randomized bench for meas_sequencer: reactive core/UART models plus a
// per-sequence timing model derived from the sequencing rules.
module tb_meas_sequencer;
  localparam int PERIOD = 8;
  localparam int TMO    = 20;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  meas_sequencer_if sif();

  meas_sequencer #(
    .PERIOD_CYC (PERIOD),
    .TIMEOUT_CYC(TMO),
    .TMR_W      (32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .sif(sif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({sif.meas_start, sif.tx_start, sif.ch_sel, sif.tx_ch,
                sif.busy, sif.timeout_err, sif.seq_cnt});
  endfunction

  // Edge index: after posedge number e, edge_n reads e until the next posedge
  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  // Per-sequence environment configuration (written by the stimulus)
  int core_lat   = 5;
  bit pre_en     = 1'b0;
  int pre_p      = 0;
  bit never_busy = 1'b0;
  int uart_d     = 0;
  int uart_b     = 1;
  bit glitch_en  = 1'b0;
  logic trig_task_n = 1'b1;
  logic glitch_n;
  assign sif.trig_n = trig_task_n & glitch_n;

  // Environment state and observed events (written by the environment only)
  int done_at = -1, busy_from = 0, busy_to = 0, pre_until = 0, glitch_at = -1;
  int ms_cnt = 0, ts_cnt = 0, idle_cnt = 0, err_rise_cnt = 0;
  int ms_cyc = 0, ts_cyc = 0, idle_cyc = 0, err_cyc = 0;
  logic ms_ch, ms_txch;
  logic prev_ms = 0, prev_ts = 0, prev_busy = 0, prev_err = 0, prev_ch = 0;
  int viol_overlap = 0, viol_double = 0, viol_ch = 0;

  // Core and UART behaviour, event recording and pulse-shape watching
  always @(negedge CLK) begin
    if (RST) begin
      done_at = -1; busy_from = 0; busy_to = 0; pre_until = 0; glitch_at = -1;
      sif.meas_done = 1'b0;
      sif.tx_busy   = 1'b0;
      glitch_n      = 1'b1;
    end else begin
      if (sif.meas_start) begin
        ms_cnt++; ms_cyc = edge_n; ms_ch = sif.ch_sel; ms_txch = sif.tx_ch;
        done_at   = (core_lat == 0) ? -1 : edge_n + core_lat;
        pre_until = pre_en ? edge_n + pre_p : 0;
        glitch_at = glitch_en ? edge_n + 9 : -1;
        if (prev_ms) viol_double++;
        if (sif.tx_start) viol_overlap++;
      end
      if (sif.tx_start) begin
        ts_cnt++; ts_cyc = edge_n;
        if (never_busy) begin
          busy_from = 0; busy_to = 0;
        end else begin
          busy_from = edge_n + uart_d; busy_to = busy_from + uart_b;
        end
        if (prev_ts) viol_double++;
      end
      sif.meas_done = (edge_n == done_at);
      sif.tx_busy   = (edge_n < pre_until) || (edge_n >= busy_from && edge_n < busy_to);
      glitch_n      = !(glitch_at >= 0 && edge_n >= glitch_at && edge_n < glitch_at + 3);
      if (prev_busy && !sif.busy) begin idle_cnt++; idle_cyc = edge_n; end
      if (sif.timeout_err && !prev_err) begin err_rise_cnt++; err_cyc = edge_n; end
      if (sif.ch_sel != prev_ch && !(prev_busy && !sif.busy)) viol_ch++;
    end
    prev_ms = sif.meas_start; prev_ts = sif.tx_start; prev_busy = sif.busy;
    prev_err = sif.timeout_err; prev_ch = sif.ch_sel;
  end

  // Reference state
  logic [15:0] m_cnt = '0;
  logic        m_ch  = 1'b0;
  logic        m_err = 1'b0;
  bit          auto_running = 1'b0;
  int          last_idle = 0;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic start_auto();
    sif.auto_en  = 1'b1;
    last_idle    = edge_n + 1;
    auto_running = 1'b1;
  endtask

  // One full sequence: drive it, then predict every event time from the rules
  task automatic run_seq(input int lat, input bit pre, input int pp, input bit never,
                         input int d, input int b, input bit glit, input bit stop);
    int s, a, t, h, ms0, ts0, idle0, err0, n, msb;
    bit sent, timed_out, err_before;
    core_lat = lat; pre_en = pre; pre_p = pp; never_busy = never;
    uart_d = d; uart_b = b; glitch_en = glit;
    ms0 = ms_cnt; ts0 = ts_cnt; idle0 = idle_cnt; err0 = err_rise_cnt;
    if (auto_running) begin
      s = last_idle + 1;
    end else begin
      trig_task_n = 1'b0;
      s = edge_n + 3;
      m_err = 1'b0;
      repeat (10) tick();
      trig_task_n = 1'b1;
    end
    n = 0;
    while (ms_cnt == ms0 && n < 100) begin tick(); n++; end
    if (stop) begin sif.auto_en = 1'b0; auto_running = 1'b0; end
    n = 0;
    while (idle_cnt == idle0 && n < 400) begin tick(); n++; end
    check("seq_end_seen", 32'(idle_cnt != idle0), 1);

    err_before = m_err;
    timed_out  = 1'b0;
    sent       = 1'b0;
    t          = 0;
    if (lat == 0 || lat > TMO - 2) begin
      h = s + TMO; timed_out = 1'b1;
    end else begin
      a = s + lat + 2;
      t = (pre && (s + pp > a)) ? s + pp + 1 : a + 1;
      sent = 1'b1;
      if (never) begin h = t + TMO; timed_out = 1'b1; end
      else begin h = t + d + b + 1; m_cnt = m_cnt + 16'd1; end
    end
    if (timed_out) m_err = 1'b1;

    check("ms_count", 32'(ms_cnt - ms0), 1);
    check("ms_time", 32'(ms_cyc), 32'(s));
    check("ms_ch", 32'(ms_ch), 32'(m_ch));
    check("tx_ch", 32'(ms_txch), 32'(m_ch));
    check("ts_count", 32'(ts_cnt - ts0), 32'(sent));
    if (sent) check("ts_time", 32'(ts_cyc), 32'(t));
    check("err_rises", 32'(err_rise_cnt - err0), 32'(timed_out && !err_before));
    if (timed_out && !err_before) check("err_time", 32'(err_cyc), 32'(h));
    check("idle_time", 32'(idle_cyc), 32'(h + PERIOD));
    if (sif.alt_en) m_ch = ~m_ch;
    check("seq_cnt", 32'(sif.seq_cnt), 32'(m_cnt));
    check("timeout_err", 32'(sif.timeout_err), 32'(m_err));
    check("ch_sel", 32'(sif.ch_sel), 32'(m_ch));
    last_idle = h + PERIOD;
    if (stop) begin
      msb = ms_cnt;
      repeat (6) tick();
      check("auto_stopped", 32'(ms_cnt - msb), 0);
      check("auto_stopped_busy", 32'(sif.busy), 0);
    end
  endtask

  initial begin
    int n, ts0;
    bit stp;
    RST = 1'b1;
    sif.auto_en = 1'b0;
    sif.alt_en  = 1'b0;
    repeat (3) tick();
    check("reset_outs", outs(), 0);
    RST = 1'b0;
    tick();
    check("idle_after_reset", outs(), 0);

    // Single shot, measurement timeout, clear by trig, busy UART at SEND, silent UART
    run_seq(5, 0, 0, 0, 1, 12, 0, 0);
    run_seq(0, 0, 0, 0, 0, 1, 0, 0);
    run_seq(5, 0, 0, 0, 0, 4, 0, 0);
    run_seq(5, 1, 35, 0, 2, 6, 0, 0);
    run_seq(5, 0, 0, 1, 0, 1, 0, 0);
    // done on the last timeout cycle wins; one later loses
    run_seq(TMO - 2, 0, 0, 0, 1, 3, 0, 0);
    run_seq(TMO - 1, 0, 0, 0, 1, 3, 0, 0);
    // trig edge mid-sequence is dropped
    run_seq(10, 0, 0, 0, 1, 5, 1, 0);

    // Auto-run with channel alternation, four sequences
    sif.alt_en = 1'b1;
    start_auto();
    for (int i = 0; i < 4; i++) run_seq(5, 0, 0, 0, 1, 12, 0, (i == 3));
    sif.alt_en = 1'b0;

    // Randomized mix of trig and auto sequences
    for (int i = 0; i < 30; i++) begin
      sif.alt_en = 1'($urandom % 2);
      if (!auto_running && ($urandom % 4 == 0)) start_auto();
      stp = auto_running && (($urandom % 3 == 0) || i == 29);
      run_seq(($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 19)),
              ($urandom % 4 == 0), int'($urandom_range(0, 40)),
              ($urandom % 8 == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 15)), ($urandom % 6 == 0), stp);
    end

    // Reset while waiting for the UART frame to end
    core_lat = 5; pre_en = 0; never_busy = 0; uart_d = 1; uart_b = 20; glitch_en = 0;
    ts0 = ts_cnt;
    trig_task_n = 1'b0;
    n = 0;
    while (ts_cnt == ts0 && n < 100) begin tick(); n++; end
    check("reach_wait_tx", 32'(ts_cnt != ts0), 1);
    trig_task_n = 1'b1;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    check("reset_mid_seq", outs(), 0);
    RST = 1'b0;
    tick();
    check("no_pulse_after_reset", outs(), 0);
    m_cnt = '0; m_ch = 1'b0; m_err = 1'b0;
    repeat (3) tick();

    // Counter wrap from 0xFFFF
    force dut.seq_cnt_q = 16'hFFFF;
    tick();
    release dut.seq_cnt_q;
    tick();
    m_cnt = 16'hFFFF;
    check("preload", 32'(sif.seq_cnt), 32'h0000_FFFF);
    run_seq(3, 0, 0, 0, 0, 2, 0, 0);

    check("start_overlap", 32'(viol_overlap), 0);
    check("pulse_double", 32'(viol_double), 0);
    check("ch_settle", 32'(viol_ch), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
